// File: rtl/bh_pkg.sv
// rtl/bh_pkg.sv - shared scene encodings, text defaults and VGA timing constants for the black-hole demo
package bh_pkg;

  typedef enum logic [1:0] {
    S_WAIT = 2'd0,
    S_FALL = 2'd1,
    S_HOLD = 2'd2
  } scene_state_t;

  localparam int unsigned Y_TOP_DEF = 20;
  localparam int unsigned Y_END_DEF = 275;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned H_TOTAL  = 800;
  localparam int unsigned V_TOTAL  = 525;

endpackage

// File: rtl/bh_frame_tick.sv
// rtl/bh_frame_tick.sv - vsync falling-edge detector producing a one-cycle frame tick and a free-running frame count
module bh_frame_tick (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vsync,
  output logic        frame_tick,
  output logic [15:0] frame_cnt
);

  logic vsync_q;

  // vsync_q resets high so the first fall after reset is seen as an edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q    <= 1'b1;
      frame_tick <= 1'b0;
      frame_cnt  <= 16'd0;
    end else begin
      vsync_q    <= vsync;
      frame_tick <= vsync_q & ~vsync;
      if (frame_tick) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

endmodule

// File: rtl/bh_scene_sequencer.sv
// rtl/bh_scene_sequencer.sv - per-frame scheduler for the UW text animation and accretion-ring phase
// Optional single-step one-shot while paused: BH_SEQ_SINGLE_STEP_EN
module bh_scene_sequencer
  import bh_pkg::*;
#(
  parameter int unsigned WAIT_FRAMES = 256,
  parameter int unsigned HOLD_FRAMES = 64,
  parameter int unsigned Y_TOP       = Y_TOP_DEF,
  parameter int unsigned Y_END       = Y_END_DEF,
  parameter int unsigned FALL_STEP   = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vsync,
  input  logic        pause,
  input  logic        restart,
  input  logic [1:0]  speed,
`ifdef BH_SEQ_SINGLE_STEP_EN
  input  logic        step,
`endif
  output logic        frame_tick,
  output logic [15:0] frame_cnt,
  output logic [9:0]  text_y,
  output logic        text_visible,
  output logic [7:0]  ring_phase,
  output logic [1:0]  scene_state
);

  scene_state_t state;
  logic [15:0]  dwell;
  logic [10:0]  fall_sum;
  logic         advance;

  bh_frame_tick u_frame_tick (
    .clk        (clk),
    .rst_n      (rst_n),
    .vsync      (vsync),
    .frame_tick (frame_tick),
    .frame_cnt  (frame_cnt)
  );

`ifdef BH_SEQ_SINGLE_STEP_EN
  logic step_q;
  logic pause_q;
  logic armed;

  // One-shot: a step edge while paused lets exactly the next tick through
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_q  <= 1'b0;
      pause_q <= 1'b0;
      armed   <= 1'b0;
    end else begin
      step_q  <= step;
      pause_q <= pause;
      if (restart || (pause_q && !pause)) begin
        armed <= 1'b0;
      end else if (frame_tick && armed) begin
        armed <= 1'b0;
      end else if (step && !step_q && pause) begin
        armed <= 1'b1;
      end
    end
  end

  assign advance = frame_tick & (~pause | armed);
`else
  assign advance = frame_tick & ~pause;
`endif

  // 11-bit sum keeps the clamp compare correct for Y_END close to the 10-bit limit
  assign fall_sum    = {1'b0, text_y} + 11'(FALL_STEP);
  assign scene_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_WAIT;
      dwell        <= 16'd0;
      text_y       <= 10'(Y_TOP);
      text_visible <= 1'b1;
      ring_phase   <= 8'd0;
    end else begin
      if (advance) begin
        ring_phase <= ring_phase + {6'd0, speed};
      end
      if (restart) begin
        state        <= S_WAIT;
        dwell        <= 16'd0;
        text_y       <= 10'(Y_TOP);
        text_visible <= 1'b1;
      end else if (advance) begin
        case (state)
          S_WAIT: begin
            if (dwell == 16'(WAIT_FRAMES - 1)) begin
              state <= S_FALL;
              dwell <= 16'd0;
            end else begin
              dwell <= dwell + 16'd1;
            end
          end
          S_FALL: begin
            if (fall_sum >= 11'(Y_END)) begin
              text_y       <= 10'(Y_END);
              text_visible <= 1'b0;
              state        <= S_HOLD;
              dwell        <= 16'd0;
            end else begin
              text_y <= fall_sum[9:0];
            end
          end
          S_HOLD: begin
            if (dwell == 16'(HOLD_FRAMES - 1)) begin
              state        <= S_WAIT;
              dwell        <= 16'd0;
              text_y       <= 10'(Y_TOP);
              text_visible <= 1'b1;
            end else begin
              dwell <= dwell + 16'd1;
            end
          end
          default: begin
            state        <= S_WAIT;
            dwell        <= 16'd0;
            text_y       <= 10'(Y_TOP);
            text_visible <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bh_scene_sequencer.sv
// tb/tb_bh_scene_sequencer.sv - directed-vector bench for bh_scene_sequencer with shortened frames
module tb_bh_scene_sequencer;

  logic        clk;
  logic        rst_n;
  logic        vsync;
  logic        pause;
  logic        restart;
  logic [1:0]  speed;
  logic        step;
  logic        frame_tick;
  logic [15:0] frame_cnt;
  logic [9:0]  text_y;
  logic        text_visible;
  logic [7:0]  ring_phase;
  logic [1:0]  scene_state;

  int          n_vec;
  int          n_miss;
  logic [15:0] exp_cnt;
  logic [15:0] cnt_snap;

  bh_scene_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .vsync        (vsync),
    .pause        (pause),
    .restart      (restart),
    .speed        (speed),
`ifdef BH_SEQ_SINGLE_STEP_EN
    .step         (step),
`endif
    .frame_tick   (frame_tick),
    .frame_cnt    (frame_cnt),
    .text_y       (text_y),
    .text_visible (text_visible),
    .ring_phase   (ring_phase),
    .scene_state  (scene_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // vsync low for one cycle; returns at the negedge after the updates land
  task automatic do_tick();
    @(negedge clk) vsync = 1'b0;
    @(negedge clk) vsync = 1'b1;
    @(negedge clk);
    exp_cnt = exp_cnt + 16'd1;
  endtask

  task automatic do_ticks(input int n);
    for (int i = 0; i < n; i++) do_tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_vec   = 0;
    n_miss  = 0;
    exp_cnt = 16'd0;
    rst_n   = 1'b0;
    vsync   = 1'b1;
    pause   = 1'b0;
    restart = 1'b0;
    speed   = 2'd0;
    step    = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_tick", frame_tick, 0);
    check("rst_cnt", frame_cnt, 0);
    check("rst_text_y", text_y, 20);
    check("rst_visible", text_visible, 1);
    check("rst_phase", ring_phase, 0);
    check("rst_state", scene_state, 0);

    // first fall: tick high exactly one cycle
    @(negedge clk) vsync = 1'b0;
    @(negedge clk) vsync = 1'b1;
    check("t1_tick_hi", frame_tick, 1);
    @(negedge clk);
    exp_cnt = 16'd1;
    check("t1_tick_lo", frame_tick, 0);
    check("t1_cnt", frame_cnt, 1);
    check("t1_text_y", text_y, 20);
    check("t1_state", scene_state, 0);

    // phase wrap: 85*3=255, 86*3=258 -> 0x02
    speed = 2'd3;
    do_ticks(85);
    check("t2_phase_ff", ring_phase, 8'hFF);
    do_tick();
    check("t2_phase_wrap", ring_phase, 8'h02);
    check("t2_cnt", frame_cnt, exp_cnt);
    speed = 2'd0;

    // restart without a tick clears the dwell count
    @(negedge clk) restart = 1'b1;
    @(negedge clk) restart = 1'b0;
    do_ticks(255);
    check("t3_wait_255", scene_state, 0);
    do_tick();
    check("t3_fall", scene_state, 1);
    check("t3_fall_y", text_y, 20);
    do_ticks(80);
    check("t4_y100", text_y, 100);

    // pause freezes scene and phase, frame_cnt keeps running
    pause    = 1'b1;
    speed    = 2'd2;
    cnt_snap = frame_cnt;
    do_ticks(10);
    check("t4_pause_y", text_y, 100);
    check("t4_pause_phase", ring_phase, 8'h02);
    check("t4_pause_state", scene_state, 1);
    check("t4_pause_cnt", frame_cnt, cnt_snap + 16'd10);
    pause = 1'b0;
    speed = 2'd0;
    do_ticks(50);
    check("t5_y150", text_y, 150);

    // restart coincident with a tick: scene resets, phase still advances
    speed = 2'd1;
    @(negedge clk) vsync = 1'b0;
    @(negedge clk) begin
      check("t5_tick_hi", frame_tick, 1);
      vsync   = 1'b1;
      restart = 1'b1;
    end
    @(negedge clk) restart = 1'b0;
    exp_cnt = exp_cnt + 16'd1;
    check("t5_state", scene_state, 0);
    check("t5_text_y", text_y, 20);
    check("t5_phase", ring_phase, 8'h03);
    check("t5_cnt", frame_cnt, exp_cnt);
    speed = 2'd0;

    // full sequence: 256 wait, 255 fall to clamp, 64 hold
    do_ticks(256);
    check("t3_fall2", scene_state, 1);
    do_ticks(254);
    check("t3_y274", text_y, 274);
    check("t3_still_fall", scene_state, 1);
    do_tick();
    check("t3_y275", text_y, 275);
    check("t3_hold", scene_state, 2);
    check("t3_hidden", text_visible, 0);
    do_ticks(63);
    check("t3_hold_63", scene_state, 2);
    do_tick();
    check("t3_back_wait", scene_state, 0);
    check("t3_back_y", text_y, 20);
    check("t3_back_vis", text_visible, 1);
    check("t3_phase_kept", ring_phase, 8'h03);

`ifdef BH_SEQ_SINGLE_STEP_EN
    do_ticks(256);
    check("t6_fall", scene_state, 1);
    pause = 1'b1;
    @(negedge clk) step = 1'b1;
    @(negedge clk) step = 1'b0;
    do_ticks(3);
    check("t6_step_y", text_y, 21);
    pause = 1'b0;
`endif

    // reset mid-frame with a fall pending
    @(negedge clk) begin
      vsync = 1'b0;
      rst_n = 1'b0;
    end
    #1;
    check("mid_rst_cnt", frame_cnt, 0);
    check("mid_rst_y", text_y, 20);
    check("mid_rst_state", scene_state, 0);
    @(negedge clk) begin
      rst_n = 1'b1;
      vsync = 1'b1;
    end
    exp_cnt = 16'd0;
    do_tick();
    check("mid_rst_tick_cnt", frame_cnt, 1);

    // frame counter wrap
    force dut.u_frame_tick.frame_cnt = 16'hFFFE;
    @(negedge clk);
    release dut.u_frame_tick.frame_cnt;
    exp_cnt = 16'hFFFE;
    do_tick();
    check("cnt_ffff", frame_cnt, 16'hFFFF);
    do_tick();
    check("cnt_wrap", frame_cnt, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
